// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for n digits; never narrower than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/add_digit.sv
// Combinational ripple of DIGIT one-bit full-adder cells; also exposes the carry into the top bit.
module add_digit #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             cin_i,
    output logic [DIGIT-1:0] sum_c_o,
    output logic             cout_c_o,
    output logic             ctop_c_o
);

    logic [DIGIT:0] carry;

    always_comb begin
        carry    = '0;
        sum_c_o  = '0;
        carry[0] = cin_i;
        for (int i = 0; i < int'(DIGIT); i++) begin
            sum_c_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign cout_c_o = carry[DIGIT];
    assign ctop_c_o = carry[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, WIDTH/DIGIT cycles per operation,
// start/busy/done handshake, result held until the next accepted start.
module serial_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = clog2(N);

    if ((DIGIT == 0) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
        $error("serial_adder: WIDTH must be a non-zero multiple of DIGIT");
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               co_q, co_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [DIGIT-1:0]   dsum;
    logic               dcout;
    logic               dctop;

    // One digit slice of the datapath, fed from the low end of the operand shift registers.
    add_digit #(
        .DIGIT (DIGIT)
    ) u_add_digit (
        .a_i      (a_q[DIGIT-1:0]),
        .b_i      (b_q[DIGIT-1:0]),
        .cin_i    (carry_q),
        .sum_c_o  (dsum),
        .cout_c_o (dcout),
        .ctop_c_o (dctop)
    );

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        s_d     = s_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1; the incoming ci is ignored in that mode.
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub ? 1'b1 : ci;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end

            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                s_d     = (s_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
                carry_d = dcout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    co_d    = dcout;
                    ovf_d   = dctop ^ dcout;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    busy_d  = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign co   = co_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: three 8-bit instances (DIGIT 4, 1, 8) checked against
// hand-computed vectors and a reference sum model.
module tb_serial_adder;

    logic       clk;
    logic       clrn;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [2:0] start_w;
    logic [2:0] busy_w;
    logic [2:0] done_w;
    logic [2:0] co_w;
    logic [2:0] ovf_w;
    logic [7:0] s_w [3];

    int nchecks = 0;
    int nerrors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .clrn(clrn), .start(start_w[0]), .sub(sub), .a(a), .b(b), .ci(ci),
        .busy(busy_w[0]), .done(done_w[0]), .s(s_w[0]), .co(co_w[0]), .ovf(ovf_w[0]));

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .clrn(clrn), .start(start_w[1]), .sub(sub), .a(a), .b(b), .ci(ci),
        .busy(busy_w[1]), .done(done_w[1]), .s(s_w[1]), .co(co_w[1]), .ovf(ovf_w[1]));

    serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .clk(clk), .clrn(clrn), .start(start_w[2]), .sub(sub), .a(a), .b(b), .ci(ci),
        .busy(busy_w[2]), .done(done_w[2]), .s(s_w[2]), .co(co_w[2]), .ovf(ovf_w[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp)
        else begin
            nerrors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: returns {ovf, co, s}.
    function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                         input logic mci, input logic msub);
        logic [7:0] bb;
        logic [8:0] sum;
        logic       v;
        bb  = msub ? ~mb : mb;
        sum = {1'b0, ma} + {1'b0, bb} + 9'(msub ? 1'b1 : mci);
        v   = (ma[7] == bb[7]) && (sum[7] != ma[7]);
        return {v, sum};
    endfunction

    // Launch one operation on all three instances, observe 12 cycles, check each.
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                          input logic tci, input logic tsub,
                          input logic [7:0] es, input logic eco, input logic eovf);
        int         lat   [3] = '{2, 8, 1};
        int         dat   [3] = '{-1, -1, -1};
        int         bcnt  [3] = '{0, 0, 0};
        int         dcnt  [3] = '{0, 0, 0};
        logic [7:0] cs    [3] = '{8'hxx, 8'hxx, 8'hxx};
        logic [2:0] cco   = 3'bxxx;
        logic [2:0] cov   = 3'bxxx;
        @(negedge clk);
        a = ta; b = tb; ci = tci; sub = tsub; start_w = 3'b111;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start_w = 3'b000;
                a = ~ta; b = ~tb; ci = ~tci; sub = ~tsub;
            end
            for (int i = 0; i < 3; i++) begin
                if (busy_w[i]) bcnt[i]++;
                if (done_w[i]) begin
                    dcnt[i]++;
                    if (dat[i] < 0) begin
                        dat[i] = k;
                        cs[i]  = s_w[i];
                        cco[i] = co_w[i];
                        cov[i] = ovf_w[i];
                    end
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s[d%0d].s", tag, 8 / lat[i]), 32'(cs[i]), 32'(es));
            chk($sformatf("%s[d%0d].co", tag, 8 / lat[i]), 32'(cco[i]), 32'(eco));
            chk($sformatf("%s[d%0d].ovf", tag, 8 / lat[i]), 32'(cov[i]), 32'(eovf));
            chk($sformatf("%s[d%0d].latency", tag, 8 / lat[i]), 32'(dat[i]), 32'(lat[i]));
            chk($sformatf("%s[d%0d].busy_width", tag, 8 / lat[i]), 32'(bcnt[i]), 32'(lat[i]));
            chk($sformatf("%s[d%0d].done_pulses", tag, 8 / lat[i]), 32'(dcnt[i]), 32'd1);
        end
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rci, rsub;
        logic [9:0] m;
        int         bcnt;
        int         dcnt;
        logic [7:0] cs;
        logic       cco, cov;

        clrn = 1'b0; start_w = 3'b000; sub = 1'b0; a = 8'h00; b = 8'h00; ci = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset[%0d].busy", i), 32'(busy_w[i]), 32'd0);
            chk($sformatf("reset[%0d].done", i), 32'(done_w[i]), 32'd0);
            chk($sformatf("reset[%0d].s", i), 32'(s_w[i]), 32'd0);
            chk($sformatf("reset[%0d].co", i), 32'(co_w[i]), 32'd0);
            chk($sformatf("reset[%0d].ovf", i), 32'(ovf_w[i]), 32'd0);
        end
        clrn = 1'b1;

        // Hand-computed vectors.
        run_op("ff_plus_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("7f_plus_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("80_plus_ff", 8'h80, 8'hFF, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1);
        run_op("05_minus_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op("07_minus_05", 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
        run_op("add_with_ci", 8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0);
        run_op("sub_ci_ignored", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op("80_minus_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        run_op("ff_plus_ff_ci", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);

        // Random vectors against the reference model.
        for (int n = 0; n < 200; n++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            rci = 1'($urandom); rsub = 1'($urandom);
            m = model(ra, rb, rci, rsub);
            run_op($sformatf("rnd%0d", n), ra, rb, rci, rsub, m[7:0], m[8], m[9]);
        end

        // start held high through RUN and DONE with changing operands must be ignored.
        @(negedge clk);
        a = 8'h80; b = 8'hFF; ci = 1'b0; sub = 1'b0; start_w = 3'b001;
        bcnt = 0; dcnt = 0; cs = 8'hxx; cco = 1'bx; cov = 1'bx;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy_w[0]) bcnt++;
            if (done_w[0]) begin
                dcnt++;
                cs = s_w[0]; cco = co_w[0]; cov = ovf_w[0];
            end
            start_w[0] = (k <= 2);
            a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom); sub = 1'($urandom);
        end
        chk("ignore_start.s", 32'(cs), 32'h7F);
        chk("ignore_start.co", 32'(cco), 32'd1);
        chk("ignore_start.ovf", 32'(cov), 32'd1);
        chk("ignore_start.busy_width", 32'(bcnt), 32'd2);
        chk("ignore_start.done_pulses", 32'(dcnt), 32'd1);

        // Reset mid-RUN discards the operation.
        @(negedge clk);
        a = 8'h12; b = 8'h34; ci = 1'b0; sub = 1'b0; start_w = 3'b001;
        @(negedge clk);
        start_w = 3'b000;
        chk("midrun.busy_before", 32'(busy_w[0]), 32'd1);
        clrn = 1'b0;
        @(negedge clk);
        chk("midrun.busy", 32'(busy_w[0]), 32'd0);
        chk("midrun.done", 32'(done_w[0]), 32'd0);
        chk("midrun.s", 32'(s_w[0]), 32'd0);
        chk("midrun.co", 32'(co_w[0]), 32'd0);
        chk("midrun.ovf", 32'(ovf_w[0]), 32'd0);
        clrn = 1'b1;
        dcnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done_w[0]) dcnt++;
        end
        chk("midrun.no_done", 32'(dcnt), 32'd0);
        run_op("after_reset", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
